axi_stream_extract_header: RTL and testbench

Downstream counterpart of the header-insert stage. It accepts a packed AXI-Stream packet, strips a per-packet number of leading header bytes and presents them on a separate header port. The remaining payload is re-aligned and repacked onto an AXI-Stream output. Used on the receive side to undo header insertion before payload processing.

---
 rtl/axi_stream_extract_header.sv | 226 ++++++++++++++++++++++
 tb/tb_axi_stream_extract_header.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_extract_header.sv
// rtl/axi_stream_extract_header.sv - strips per-packet leading header bytes from an AXI-Stream packet
//
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   valid_in/data_in/keep_in/last_in/ready_in   packed input stream (byte 0 at MSB)
//   valid_len/len_in/ready_len             header byte count for the next packet
//   valid_out/data_out/keep_out/last_out/ready_out  re-aligned payload stream (MSB-justified)
//   valid_hdr/header_out/keep_hdr/ready_hdr         extracted header (LSB-justified)
module axi_stream_extract_header #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int LEN_WD       = $clog2(DATA_BYTE_WD) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    input  logic                    valid_len,
    input  logic [LEN_WD-1:0]       len_in,
    output logic                    ready_len,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    valid_hdr,
    output logic [DATA_WD-1:0]      header_out,
    output logic [DATA_BYTE_WD-1:0] keep_hdr,
    input  logic                    ready_hdr
);

    localparam logic [LEN_WD-1:0] BYTES = LEN_WD'(DATA_BYTE_WD);

    typedef enum logic [1:0] {IDLE, BODY, TAIL} state_t;

    state_t                  r_state;
    logic                    r_len_valid;
    logic [LEN_WD-1:0]       r_len_pend;
    logic [LEN_WD-1:0]       r_cur_s;
    logic [DATA_WD-1:0]      r_resid;
    logic [LEN_WD-1:0]       r_resid_n;
    logic                    r_valid_out;
    logic [DATA_WD-1:0]      r_data_out;
    logic [DATA_BYTE_WD-1:0] r_keep_out;
    logic                    r_last_out;
    logic                    r_valid_hdr;
    logic [DATA_WD-1:0]      r_header;
    logic [DATA_BYTE_WD-1:0] r_keep_hdr;

    function automatic logic [LEN_WD-1:0] f_count(input logic [DATA_BYTE_WD-1:0] k);
        logic [LEN_WD-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) cnt = cnt + LEN_WD'(k[i]);
        return cnt;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] f_keep_msb(input logic [LEN_WD-1:0] c);
        logic [DATA_BYTE_WD-1:0] k;
        for (int i = 0; i < DATA_BYTE_WD; i++) k[DATA_BYTE_WD-1-i] = (LEN_WD'(i) < c);
        return k;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] f_keep_lsb(input logic [LEN_WD-1:0] c);
        logic [DATA_BYTE_WD-1:0] k;
        for (int i = 0; i < DATA_BYTE_WD; i++) k[i] = (LEN_WD'(i) < c);
        return k;
    endfunction

    logic                    w_hdr_free;
    logic                    w_out_free;
    logic                    w_in_hs;
    logic                    w_len_hs;
    logic [LEN_WD-1:0]       w_n;
    logic [LEN_WD-1:0]       w_s_first;
    logic [LEN_WD-1:0]       w_s_sel;
    logic [LEN_WD+2:0]       w_shl;
    logic [LEN_WD+2:0]       w_shr;
    logic [DATA_WD-1:0]      w_din;
    logic [DATA_WD-1:0]      w_in_shl;
    logic [DATA_WD-1:0]      w_in_shr;

    // Bytes beyond keep are zeroed so they never leak into repacked beats.
    always_comb begin
        w_din = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) w_din[8*i +: 8] = data_in[8*i +: 8] & {8{keep_in[i]}};
    end

    assign w_hdr_free = !r_valid_hdr || ready_hdr;
    assign w_out_free = !r_valid_out || ready_out;
    assign w_n        = f_count(keep_in);
    // Only a last first beat can be shorter than s; clamp to what is present.
    assign w_s_first  = (r_len_pend > w_n) ? w_n : r_len_pend;
    assign w_s_sel    = (r_state == IDLE) ? w_s_first : r_cur_s;
    assign w_shl      = {w_s_sel, 3'b000};
    assign w_shr      = {BYTES - w_s_sel, 3'b000};
    assign w_in_shl   = w_din << w_shl;
    assign w_in_shr   = w_din >> w_shr;

    // A pending length can be taken while a packet is in flight, but only once
    // the previous header has left, so the first beat always finds it free.
    assign ready_len  = !rst && !r_len_valid && w_hdr_free;

    always_comb begin
        ready_in = 1'b0;
        case (r_state)
            IDLE:    ready_in = r_len_valid && w_out_free;
            BODY:    ready_in = w_out_free;
            default: ready_in = 1'b0;
        endcase
        if (rst) ready_in = 1'b0;
    end

    assign w_in_hs  = valid_in && ready_in;
    assign w_len_hs = valid_len && ready_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_len_valid <= 1'b0;
            r_len_pend  <= '0;
            r_cur_s     <= '0;
            r_resid     <= '0;
            r_resid_n   <= '0;
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
            r_keep_out  <= '0;
            r_last_out  <= 1'b0;
            r_valid_hdr <= 1'b0;
            r_header    <= '0;
            r_keep_hdr  <= '0;
        end else begin
            if (w_len_hs) begin
                r_len_valid <= 1'b1;
                r_len_pend  <= len_in;
            end
            if (r_valid_out && ready_out) r_valid_out <= 1'b0;
            if (r_valid_hdr && ready_hdr) begin
                r_valid_hdr <= 1'b0;
                r_header    <= '0;
                r_keep_hdr  <= '0;
            end
            case (r_state)
                IDLE: begin
                    if (w_in_hs) begin
                        r_len_valid <= 1'b0;
                        r_cur_s     <= w_s_first;
                        if (w_s_first == '0) begin
                            // No header: the beat goes straight to the output register.
                            r_valid_out <= 1'b1;
                            r_data_out  <= w_din;
                            r_keep_out  <= keep_in;
                            r_last_out  <= last_in;
                            r_state     <= last_in ? IDLE : BODY;
                        end else begin
                            r_valid_hdr <= 1'b1;
                            r_header    <= w_in_shr;
                            r_keep_hdr  <= f_keep_lsb(w_s_first);
                            r_resid     <= w_in_shl;
                            r_resid_n   <= w_n - w_s_first;
                            if (last_in) begin
                                if (w_n != w_s_first) begin
                                    r_valid_out <= 1'b1;
                                    r_data_out  <= w_in_shl;
                                    r_keep_out  <= f_keep_msb(w_n - w_s_first);
                                    r_last_out  <= 1'b1;
                                end
                                r_state <= IDLE;
                            end else begin
                                r_state <= BODY;
                            end
                        end
                    end
                end
                BODY: begin
                    if (w_in_hs) begin
                        r_valid_out <= 1'b1;
                        if (r_cur_s == '0) begin
                            r_data_out <= w_din;
                            r_keep_out <= keep_in;
                            r_last_out <= last_in;
                            if (last_in) r_state <= IDLE;
                        end else begin
                            // Residual fills the top W-s bytes, the new beat's first s bytes the rest.
                            r_data_out <= r_resid | w_in_shr;
                            r_resid    <= w_in_shl;
                            if (last_in && (w_n <= r_cur_s)) begin
                                r_keep_out <= f_keep_msb(BYTES - r_cur_s + w_n);
                                r_last_out <= 1'b1;
                                r_state    <= IDLE;
                            end else begin
                                r_keep_out <= '1;
                                r_last_out <= 1'b0;
                                if (last_in) begin
                                    r_resid_n <= w_n - r_cur_s;
                                    r_state   <= TAIL;
                                end
                            end
                        end
                    end
                end
                TAIL: begin
                    if (w_out_free) begin
                        r_valid_out <= 1'b1;
                        r_data_out  <= r_resid;
                        r_keep_out  <= f_keep_msb(r_resid_n);
                        r_last_out  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign valid_out  = r_valid_out;
    assign data_out   = r_data_out;
    assign keep_out   = r_keep_out;
    assign last_out   = r_last_out;
    assign valid_hdr  = r_valid_hdr;
    assign header_out = r_header;
    assign keep_hdr   = r_keep_hdr;

endmodule

// File: tb/tb_axi_stream_extract_header.sv
// tb/tb_axi_stream_extract_header.sv - directed self-checking bench for axi_stream_extract_header
module tb_axi_stream_extract_header;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [31:0] data_in;
    logic [3:0]  keep_in;
    logic        last_in;
    logic        ready_in;
    logic        valid_len;
    logic [2:0]  len_in;
    logic        ready_len;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out;
    logic        valid_hdr;
    logic [31:0] header_out;
    logic [3:0]  keep_hdr;
    logic        ready_hdr;

    int n_assert = 0;
    int n_fail   = 0;

    logic [36:0] q_out[$];
    logic [35:0] q_hdr[$];
    int out_rd = 0;
    int hdr_rd = 0;

    axi_stream_extract_header #(.DATA_WD(32)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
        .valid_len(valid_len), .len_in(len_in), .ready_len(ready_len),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
        .valid_hdr(valid_hdr), .header_out(header_out), .keep_hdr(keep_hdr), .ready_hdr(ready_hdr)
    );

    always #5 clk = ~clk;

    // Inputs change at posedge+1, so values seen here are the ones the next posedge uses.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_out && ready_out) q_out.push_back({last_out, keep_out, data_out});
            if (valid_hdr && ready_hdr) q_hdr.push_back({keep_hdr, header_out});
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_len(input logic [2:0] s);
        int t;
        t = 0;
        valid_len = 1'b1;
        len_in    = s;
        @(negedge clk);
        while (!ready_len && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("len_timeout", 64'(ready_len), 64'd1);
        @(posedge clk); #1;
        valid_len = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        t = 0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        @(negedge clk);
        while (!ready_in && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check("beat_timeout", 64'(ready_in), 64'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        if (out_rd < q_out.size()) begin
            check(tag, 64'(q_out[out_rd]), 64'({l, k, d}));
            out_rd++;
        end else begin
            check({tag, "_missing"}, 64'(q_out.size()), 64'(out_rd + 1));
        end
    endtask

    task automatic expect_hdr(input string tag, input logic [31:0] h, input logic [3:0] k);
        if (hdr_rd < q_hdr.size()) begin
            check(tag, 64'(q_hdr[hdr_rd]), 64'({k, h}));
            hdr_rd++;
        end else begin
            check({tag, "_missing"}, 64'(q_hdr.size()), 64'(hdr_rd + 1));
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt1();
        send_len(3'd3);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b0);
        send_beat(32'hEEFF0011, 4'b1111, 1'b0);
        send_beat(32'h00AABBCC, 4'b1100, 1'b1);
    endtask

    logic [3:0]  pat = 4'b1001;
    logic        stalled;
    logic [36:0] stall_val;

    initial begin
        rst = 1'b1; valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_len = 1'b0; len_in = '0; ready_out = 1'b1; ready_hdr = 1'b1;
        stalled = 1'b0; stall_val = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valids", 64'({valid_out, last_out, valid_hdr, ready_in, ready_len}), 64'd0);
        check("rst_data", 64'({keep_out, data_out}), 64'd0);
        check("rst_hdr", 64'({keep_hdr, header_out}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // s=3, three beats
        send_pkt1();
        idle_cycles(4);
        expect_hdr("t1_hdr", 32'h00AABBCC, 4'b0111);
        expect_out("t1_b0", 32'hDDEEFF00, 4'b1111, 1'b0);
        expect_out("t1_b1", 32'h1100AA00, 4'b1110, 1'b1);
        check("t1_count", 64'(q_out.size()), 64'(out_rd));

        // s=1, tail beat
        send_len(3'd1);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        send_beat(32'h55667788, 4'b1110, 1'b1);
        @(negedge clk);
        check("t2_tail_ready_in", 64'(ready_in), 64'd0);
        idle_cycles(4);
        expect_hdr("t2_hdr", 32'h00000011, 4'b0001);
        expect_out("t2_b0", 32'h22334455, 4'b1111, 1'b0);
        expect_out("t2_b1", 32'h66770000, 4'b1100, 1'b1);
        check("t2_count", 64'(q_out.size()), 64'(out_rd));

        // s=0 pass-through
        send_len(3'd0);
        send_beat(32'h01020304, 4'b1111, 1'b0);
        send_beat(32'h05060708, 4'b1111, 1'b0);
        send_beat(32'h09000000, 4'b1000, 1'b1);
        @(negedge clk);
        check("t3_latency", 64'({valid_out, last_out, keep_out, data_out}), 64'({1'b1, 1'b1, 4'b1000, 32'h09000000}));
        idle_cycles(4);
        expect_out("t3_b0", 32'h01020304, 4'b1111, 1'b0);
        expect_out("t3_b1", 32'h05060708, 4'b1111, 1'b0);
        expect_out("t3_b2", 32'h09000000, 4'b1000, 1'b1);
        check("t3_no_hdr", 64'(q_hdr.size()), 64'(hdr_rd));

        // single beat, whole beat is header
        send_len(3'd4);
        send_beat(32'hAABBCCDD, 4'b1111, 1'b1);
        idle_cycles(4);
        expect_hdr("t4_hdr", 32'hAABBCCDD, 4'b1111);
        check("t4_no_payload", 64'(q_out.size()), 64'(out_rd));
        check("t4_idle", 64'(dut.r_state), 64'd0);

        // backpressure on the payload output
        fork
            send_pkt1();
            begin
                for (int c = 0; c < 24; c++) begin
                    ready_out = pat[c % 4];
                    @(negedge clk);
                    if (stalled)
                        check("t5_stall_hold", 64'({valid_out, last_out, keep_out, data_out}), 64'({1'b1, stall_val}));
                    if (valid_out && !ready_out) begin
                        check("t5_stall_ready_in", 64'(ready_in), 64'd0);
                        stalled   = 1'b1;
                        stall_val = {last_out, keep_out, data_out};
                    end else begin
                        stalled = 1'b0;
                    end
                    @(posedge clk); #1;
                end
                ready_out = 1'b1;
            end
        join
        idle_cycles(4);
        expect_hdr("t5_hdr", 32'h00AABBCC, 4'b0111);
        expect_out("t5_b0", 32'hDDEEFF00, 4'b1111, 1'b0);
        expect_out("t5_b1", 32'h1100AA00, 4'b1110, 1'b1);
        check("t5_count", 64'(q_out.size()), 64'(out_rd));

        // header held by ready_hdr=0 blocks the next length
        ready_hdr = 1'b0;
        send_pkt1();
        valid_len = 1'b1;
        len_in    = 3'd2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t6_ready_len_blocked", 64'(ready_len), 64'd0);
            check("t6_hdr_held", 64'({valid_hdr, keep_hdr, header_out}), 64'({1'b1, 4'b0111, 32'h00AABBCC}));
        end
        @(posedge clk); #1;
        ready_hdr = 1'b1;
        send_len(3'd2);
        send_beat(32'h12345678, 4'b1111, 1'b0);
        send_beat(32'h9ABC0000, 4'b1100, 1'b1);
        idle_cycles(4);
        expect_hdr("t6_hdr_a", 32'h00AABBCC, 4'b0111);
        expect_hdr("t6_hdr_b", 32'h00001234, 4'b0011);
        expect_out("t6_a0", 32'hDDEEFF00, 4'b1111, 1'b0);
        expect_out("t6_a1", 32'h1100AA00, 4'b1110, 1'b1);
        expect_out("t6_b0", 32'h56789ABC, 4'b1111, 1'b1);

        // reset mid-packet
        ready_out = 1'b0;
        ready_hdr = 1'b0;
        send_len(3'd1);
        send_beat(32'hC0C1C2C3, 4'b1111, 1'b0);
        send_beat(32'hD0D1D2D3, 4'b1111, 1'b0);
        @(negedge clk);
        check("t7_pre_rst", 64'({valid_out, valid_hdr, data_out}), 64'({1'b1, 1'b1, 32'hC1C2C3D0}));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t7_post_rst", 64'({valid_out, last_out, valid_hdr, ready_in}), 64'd0);
        check("t7_state", 64'(dut.r_state), 64'd0);
        ready_out = 1'b1;
        ready_hdr = 1'b1;
        idle_cycles(3);
        check("t7_no_out", 64'(q_out.size()), 64'(out_rd));
        check("t7_no_hdr", 64'(q_hdr.size()), 64'(hdr_rd));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
